// File: rtl/mat_pkg.sv
// Shared definitions for the matrix reader/writer slice: default sizes,
// index-width derivation and the load/store handshake state encoding.
package mat_pkg;

   localparam int N_DEFAULT      = 8;
   localparam int DATA_W_DEFAULT = 32;

   // Row/column index width for a dim x dim matrix (never narrower than one bit).
   function automatic int idx_width(input int dim);
      return (dim < 2) ? 1 : $clog2(dim);
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mat_state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (i, j) walker over an n x n matrix, shared by reader and writer.
// last flags the final element (n-1, n-1); stepping past it wraps to (0, 0).
module matrix_index_counter
   import mat_pkg::*;
#(
   parameter int n     = N_DEFAULT,
   parameter int IDX_W = idx_width(n)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic             last
);

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(n - 1);

   // Advance column first, carrying into the row; clr takes priority over inc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i <= '0;
         j <= '0;
      end else if (clr) begin
         i <= '0;
         j <= '0;
      end else if (inc) begin
         if (j == MAX_IDX) begin
            j <= '0;
            i <= (i == MAX_IDX) ? '0 : i + IDX_W'(1);
         end else begin
            j <= j + IDX_W'(1);
         end
      end
   end

   assign last = (i == MAX_IDX) && (j == MAX_IDX);

endmodule

// File: rtl/matrix_reader.sv
// Fetches an n x n matrix one element at a time from an external source
// (req out, value/value_valid back) into a local buffer, and serves the
// buffer through a combinational random-access read port.
module matrix_reader
   import mat_pkg::*;
#(
   parameter int n      = N_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int IDX_W  = idx_width(n)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [IDX_W-1:0]  i,
   output logic [IDX_W-1:0]  j,
   output logic              req,
   input  logic [DATA_W-1:0] value,
   input  logic              value_valid,
   output logic              busy,
   output logic              done,
   input  logic [IDX_W-1:0]  rd_i,
   input  logic [IDX_W-1:0]  rd_j,
   output logic [DATA_W-1:0] rd_value
);

   mat_state_t        state;
   mat_state_t        state_next;
   logic              idx_clr;
   logic              idx_inc;
   logic              idx_last;
   logic              wr_en;
   logic [DATA_W-1:0] buffer [n][n];

   matrix_index_counter #(
      .n     (n),
      .IDX_W (IDX_W)
   ) u_index (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idx_clr),
      .inc   (idx_inc),
      .i     (i),
      .j     (j),
      .last  (idx_last)
   );

   // State register; reset abandons any load in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // One request outstanding at a time; a value is only taken while waiting for it.
   always_comb begin
      state_next = state;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               idx_clr    = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (value_valid) begin
               wr_en      = 1'b1;
               idx_inc    = 1'b1;
               state_next = idx_last ? DONE : REQ;
            end
         end
         DONE: begin
            idx_clr    = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign req  = (state == REQ);
   assign busy = (state == REQ) || (state == WAIT);
   assign done = (state == DONE);

   // Element store at the current index; reset wipes the whole matrix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
               buffer[r][c] <= '0;
            end
         end
      end else if (wr_en) begin
         buffer[i][j] <= value;
      end
   end

   // Read port: indices beyond the matrix only exist when n is not a power of two.
   generate
      if (n == (1 << IDX_W)) begin : g_full_range
         assign rd_value = buffer[rd_i][rd_j];
      end else begin : g_partial_range
         localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(n);
         assign rd_value = (({1'b0, rd_i} < N_EXT) && ({1'b0, rd_j} < N_EXT))
                           ? buffer[rd_i][rd_j] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_matrix_reader.sv
// Bench for matrix_reader: a responding word source, a transaction-level
// model of the load (element k lands at k/N, k%N), and a per-cycle compare.
module tb_matrix_reader;

   localparam int N     = 8;
   localparam int DW    = 32;
   localparam int IW    = $clog2(N);
   localparam int NN    = N * N;
   localparam int LIMIT = 3000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [IW-1:0] i;
   logic [IW-1:0] j;
   logic          req;
   logic [DW-1:0] value;
   logic          value_valid;
   logic          busy;
   logic          done;
   logic [IW-1:0] rd_i;
   logic [IW-1:0] rd_j;
   logic [DW-1:0] rd_value;

   // Source behaviour knobs, written by the main sequence only.
   int src_base  = 0;
   bit src_rand  = 1'b0;
   bit spur_idle = 1'b0;
   bit spur_req  = 1'b0;
   bit rd_rand   = 1'b1;

   // Reference model state.
   bit            m_busy;
   bit            m_wait;
   bit            m_req;
   bit            m_done;
   int            m_k;
   logic [DW-1:0] m_mem [NN];

   // Bookkeeping and score.
   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int req_cnt   = 0;
   int done_cnt  = 0;
   int busy_cyc  = 0;
   int done_cyc  = 0;
   int busy_gap  = 0;
   bit busy_prev = 1'b0;
   bit done_s    = 1'b0;

   matrix_reader #(
      .n      (N),
      .DATA_W (DW),
      .IDX_W  (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .i           (i),
      .j           (j),
      .req         (req),
      .value       (value),
      .value_valid (value_valid),
      .busy        (busy),
      .done        (done),
      .rd_i        (rd_i),
      .rd_j        (rd_j),
      .rd_value    (rd_value)
   );

   always #5 clk = ~clk;

   // Transaction model: a start from idle opens a load; each request is answered
   // by exactly one value taken after the request cycle; the NN-th value closes it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_wait <= 1'b0;
         m_req  <= 1'b0;
         m_done <= 1'b0;
         m_k    <= 0;
         for (int a = 0; a < NN; a++) m_mem[a] <= '0;
      end else begin
         m_req  <= 1'b0;
         m_done <= 1'b0;
         if (!m_busy && !m_done && start) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_req  <= 1'b1;
         end else if (m_req) begin
            m_wait <= 1'b1;
         end else if (m_wait && value_valid) begin
            m_mem[m_k] <= value;
            m_wait     <= 1'b0;
            if (m_k == NN - 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end else begin
               m_k   <= m_k + 1;
               m_req <= 1'b1;
            end
         end
      end
   end

   // Word source: answers each request after 1..6 cycles with base + N*i + j,
   // optionally injecting bogus valids in idle and in the request cycle.
   initial begin : source
      int d;
      value       = '0;
      value_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         value_valid = 1'b0;
         if (spur_idle && !busy) begin
            value       = 32'hDEADBEEF;
            value_valid = 1'b1;
         end
         while (req && rst_n) begin
            if (spur_req) begin
               value       = 32'hDEADBEEF;
               value_valid = 1'b1;
            end else begin
               value_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            value_valid = 1'b0;
            d = src_rand ? int'($urandom_range(0, 5)) : 0;
            repeat (d) begin
               @(posedge clk);
               #1;
            end
            value       = DW'(src_base + N * int'(i) + int'(j));
            value_valid = 1'b1;
            @(posedge clk);
            #1;
            value_valid = 1'b0;
         end
      end
   end

   task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkOutput();
      int ei;
      int ej;
      ei = m_busy ? m_k / N : 0;
      ej = m_busy ? m_k % N : 0;
      checkVal("busy", DW'(busy), DW'(m_busy));
      checkVal("req", DW'(req), DW'(m_req));
      checkVal("done", DW'(done), DW'(m_done));
      checkVal("i", DW'(i), DW'(ei));
      checkVal("j", DW'(j), DW'(ej));
      checkVal("rd_value", rd_value, m_mem[int'(rd_i) * N + int'(rd_j)]);
   endtask

   // One clock: compare at the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      checkOutput();
      if (req) req_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy && !busy_prev) busy_cyc = cyc;
      if (busy_prev && !busy && !done) busy_gap++;
      busy_prev = busy;
      done_s    = done;
      cyc++;
      @(posedge clk);
      #1;
      if (rd_rand) begin
         rd_i = IW'($urandom_range(0, N - 1));
         rd_j = IW'($urandom_range(0, N - 1));
      end
   endtask

   task automatic applyStimulus(input int base, input bit rnd);
      src_base = base;
      src_rand = rnd;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int c;
      c      = 0;
      done_s = 1'b0;
      while (!done_s && c < LIMIT) begin
         tick();
         c++;
      end
      checkVal(name, DW'(done_s), DW'(1));
   endtask

   task automatic waitElem(input string name, input int k);
      int c;
      c = 0;
      while (!(m_busy && m_k == k) && c < LIMIT) begin
         tick();
         c++;
      end
      checkVal(name, DW'(m_k), DW'(k));
   endtask

   task automatic checkAt(input string name, input int r, input int c, input logic [DW-1:0] exp);
      rd_i = IW'(r);
      rd_j = IW'(c);
      #1;
      checkVal(name, rd_value, exp);
      checkVal({name, "_model"}, m_mem[r * N + c], exp);
   endtask

   task automatic sweep();
      rd_rand = 1'b0;
      for (int a = 0; a < NN; a++) begin
         rd_i = IW'(a / N);
         rd_j = IW'(a % N);
         tick();
      end
      rd_rand = 1'b1;
   endtask

   // Main sequence.
   initial begin : main
      int r0;
      int d0;
      int d1;
      rst_n = 1'b0;
      start = 1'b0;
      rd_i  = '0;
      rd_j  = '0;
      repeat (3) tick();
      checkVal("reset_busy", DW'(busy), DW'(0));
      checkVal("reset_req", DW'(req), DW'(0));
      checkVal("reset_done", DW'(done), DW'(0));
      checkVal("reset_ij", DW'({i, j}), DW'(0));
      rst_n = 1'b1;
      repeat (2) tick();

      $display("[TB] sequential load");
      r0 = req_cnt;
      applyStimulus(0, 1'b0);
      waitDone("seq_done");
      checkVal("seq_latency", DW'(done_cyc - busy_cyc), DW'(2 * NN));
      checkVal("seq_reqs", DW'(req_cnt - r0), DW'(NN));
      checkAt("seq_rd_3_5", 3, 5, 32'd29);
      checkAt("seq_rd_7_7", 7, 7, 32'd63);

      $display("[TB] variable latency");
      r0 = req_cnt;
      d0 = done_cnt;
      applyStimulus(1000, 1'b1);
      waitDone("var_done");
      repeat (2) tick();
      checkVal("var_reqs", DW'(req_cnt - r0), DW'(NN));
      checkVal("var_dones", DW'(done_cnt - d0), DW'(1));
      checkVal("var_busy_gap", DW'(busy_gap), DW'(0));
      sweep();

      $display("[TB] spurious valid");
      spur_idle = 1'b1;
      repeat (6) tick();
      spur_idle = 1'b0;
      checkVal("spur_idle_ij", DW'({i, j}), DW'(0));
      checkAt("spur_idle_rd_2_2", 2, 2, 32'd1018);
      spur_req = 1'b1;
      r0 = req_cnt;
      applyStimulus(2000, 1'b0);
      waitDone("spur_done");
      spur_req = 1'b0;
      checkVal("spur_reqs", DW'(req_cnt - r0), DW'(NN));
      checkAt("spur_rd_4_6", 4, 6, 32'd2038);
      sweep();

      $display("[TB] start while busy");
      r0 = req_cnt;
      d0 = done_cnt;
      applyStimulus(3000, 1'b1);
      waitElem("busy_elem10", 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      waitDone("busy_done");
      repeat (4) tick();
      checkVal("busy_dones", DW'(done_cnt - d0), DW'(1));
      checkVal("busy_reqs", DW'(req_cnt - r0), DW'(NN));
      checkAt("busy_rd_1_2", 1, 2, 32'd3010);

      $display("[TB] reset mid-load");
      applyStimulus(4000, 1'b1);
      waitElem("rst_elem20", 20);
      rst_n = 1'b0;
      #1;
      checkVal("rst_busy", DW'(busy), DW'(0));
      checkVal("rst_req", DW'(req), DW'(0));
      checkAt("rst_rd_0_0", 0, 0, 32'd0);
      checkAt("rst_rd_2_3", 2, 3, 32'd0);
      checkAt("rst_rd_7_7", 7, 7, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      applyStimulus(5000, 1'b0);
      checkVal("rst_first_req", DW'(req), DW'(1));
      checkVal("rst_first_ij", DW'({i, j}), DW'(0));
      waitDone("rst_reload_done");
      checkAt("rst_rd_2_3_new", 2, 3, 32'd5019);
      checkAt("rst_rd_7_7_new", 7, 7, 32'd5063);

      $display("[TB] back-to-back");
      src_base = 0;
      src_rand = 1'b0;
      start    = 1'b1;
      tick();
      waitDone("b2b_done1");
      d1       = done_cyc;
      src_base = 100;
      tick();
      start    = 1'b0;
      checkVal("b2b_restart", DW'(busy), DW'(1));
      waitDone("b2b_done2");
      checkVal("b2b_gap", DW'(done_cyc - d1), DW'(2 * NN + 2));
      checkAt("b2b_rd_0_1", 0, 1, 32'd101);
      checkAt("b2b_rd_7_7", 7, 7, 32'd163);
      sweep();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Last-resort stop in case the sequence itself wedges.
   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
